// File: rtl/clip_play_scheduler_pkg.sv
// Clip ROM map, clip indices and scheduler FSM encoding shared by the
// clip play scheduler and its bench.
package clip_pkg;
  localparam int NUM_CLIPS = 4;

  localparam logic [1:0] CLIP_WIN    = 2'd0;
  localparam logic [1:0] CLIP_MOO    = 2'd1;
  localparam logic [1:0] CLIP_DETECT = 2'd2;
  localparam logic [1:0] CLIP_CHEER  = 2'd3;

  // Element i is clip i (win at index 0).
  localparam logic [NUM_CLIPS-1:0][31:0] CLIP_START =
    {32'd83255, 32'd66983, 32'd16396, 32'd0};
  localparam logic [NUM_CLIPS-1:0][31:0] CLIP_END =
    {32'd137138, 32'd83254, 32'd66982, 32'd16395};

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HOLD, ST_WAIT} state_e;

  // Fixed priority: highest set index wins.
  function automatic logic [1:0] pick_clip(input logic [NUM_CLIPS-1:0] req);
    pick_clip = CLIP_WIN;
    for (int i = 0; i < NUM_CLIPS; i++)
      if (req[i]) pick_clip = 2'(i);
  endfunction
endpackage

// File: rtl/clip_play_scheduler_if.sv
// Request, clip ROM and codec write bundle around the clip play scheduler.
interface clip_play_scheduler_if #(
  parameter int ADDR_W   = 18,
  parameter int SAMPLE_W = 6
);
  logic [3:0]          play_req;
  logic                stop;
  logic [SAMPLE_W-1:0] rom_q;
  logic                audio_out_allowed;
  logic [ADDR_W-1:0]   rom_addr;
  logic [31:0]         left_out;
  logic                write_audio_out;
  logic                playing;
  logic [1:0]          active_clip;
  logic                clip_done;
  logic [7:0]          underrun_cnt;

  modport master (
    input  play_req, stop, rom_q, audio_out_allowed,
    output rom_addr, left_out, write_audio_out, playing, active_clip,
           clip_done, underrun_cnt
  );
  modport slave (
    output play_req, stop, rom_q, audio_out_allowed,
    input  rom_addr, left_out, write_audio_out, playing, active_clip,
           clip_done, underrun_cnt
  );
endinterface

// File: rtl/clip_play_scheduler_tick_gen.sv
// Sample-rate divider: tick on the last count of each SAMPLE_DIV period.
module sample_tick_gen #(
  parameter int DIV = 1200
)(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/clip_play_scheduler.sv
// Queues clip play requests, arbitrates by fixed priority and streams the
// chosen clip's ROM words to the codec at the sample rate.
module clip_play_scheduler #(
  parameter int SAMPLE_DIV = 1200,
  parameter int ROM_LAT    = 2,
  parameter int ADDR_W     = 18,
  parameter int SAMPLE_W   = 6
)(
  input  logic CLOCK_50,
  input  logic resetn,
  clip_play_scheduler_if.master bus
);
  import clip_pkg::*;

  localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam int PAD_W = 32 - SAMPLE_W;

  state_e              state_q, state_d;
  logic [3:0]          pending_q, pending_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          clip_q, clip_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [31:0]         left_q, left_d;
  logic                write_q, write_d;
  logic                playing_q, playing_d;
  logic                done_q, done_d;
  logic [7:0]          und_q, und_d;

  logic [1:0] sel;
  logic       preempt, clr_pend, tick, tick_clr;

  // Counter stays at zero in IDLE; a stop clears it on the way there.
  assign tick_clr = (state_q == ST_IDLE) || bus.stop;

  sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
    .clk  (CLOCK_50),
    .rst_n(resetn),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign sel     = pick_clip(pending_q);
  assign preempt = (|pending_q) && (sel > clip_q);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    clip_d   = clip_q;
    lat_d    = lat_q;
    sample_d = sample_q;
    left_d   = left_q;
    write_d  = 1'b0;
    done_d   = 1'b0;
    und_d    = und_q;
    clr_pend = 1'b0;

    case (state_q)
      ST_IDLE: if (|pending_q) begin
        state_d  = ST_FETCH;
        addr_d   = ADDR_W'(CLIP_START[sel]);
        clip_d   = sel;
        lat_d    = '0;
        clr_pend = 1'b1;
      end
      ST_FETCH: begin
        if (lat_q == LAT_W'(ROM_LAT - 1)) begin
          sample_d = bus.rom_q;
          state_d  = ST_HOLD;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      ST_HOLD: if (bus.audio_out_allowed) begin
        write_d = 1'b1;
        left_d  = {sample_q, {PAD_W{1'b0}}};
        state_d = ST_WAIT;
      end
      ST_WAIT: if (tick) begin
        lat_d   = '0;
        state_d = ST_FETCH;
        if (preempt) begin
          addr_d   = ADDR_W'(CLIP_START[sel]);
          clip_d   = sel;
          clr_pend = 1'b1;
        end else if (addr_q == ADDR_W'(CLIP_END[clip_q])) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A tick that lands before the current word is written is lost.
    if (tick && (state_q == ST_FETCH || state_q == ST_HOLD) && und_q != 8'hFF)
      und_d = und_q + 8'd1;

    // New requests override the start-clear of the same clip.
    pending_d = (pending_q & ~(clr_pend ? (4'b0001 << sel) : 4'b0000)) | bus.play_req;

    if (bus.stop) begin
      state_d   = ST_IDLE;
      pending_d = '0;
      done_d    = 1'b0;
      write_d   = 1'b0;
    end

    playing_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      addr_q    <= '0;
      clip_q    <= '0;
      lat_q     <= '0;
      sample_q  <= '0;
      left_q    <= '0;
      write_q   <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
      und_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      clip_q    <= clip_d;
      lat_q     <= lat_d;
      sample_q  <= sample_d;
      left_q    <= left_d;
      write_q   <= write_d;
      playing_q <= playing_d;
      done_q    <= done_d;
      und_q     <= und_d;
    end
  end

  assign bus.rom_addr        = addr_q;
  assign bus.left_out        = left_q;
  assign bus.write_audio_out = write_q;
  assign bus.playing         = playing_q;
  assign bus.active_clip     = clip_q;
  assign bus.clip_done       = done_q;
  assign bus.underrun_cnt    = und_q;
endmodule

// File: tb/tb_clip_play_scheduler.sv
// Directed bench for clip_play_scheduler with a short sample period and a
// one-register ROM model whose word is a fold of its address.
module tb_clip_play_scheduler;
  localparam int DIV = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, wr_seen = 0, done_seen = 0;

  clip_play_scheduler_if #(.ADDR_W(18), .SAMPLE_W(6)) bus ();

  clip_play_scheduler #(.SAMPLE_DIV(DIV), .ROM_LAT(LAT), .ADDR_W(18), .SAMPLE_W(6)) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] rom_word(input logic [17:0] a);
    return a[5:0] ^ a[11:6];
  endfunction

  always @(posedge clk) bus.rom_q <= rom_word(bus.rom_addr);

  task automatic step();
    @(negedge clk);
    if (bus.write_audio_out) wr_seen++;
    if (bus.clip_done) done_seen++;
  endtask

  task automatic test_reset();
    step(); step();
    n_chk++; if (bus.rom_addr !== 18'd0) $display("FAIL rst_addr got %0d want 0", bus.rom_addr); else n_pass++;
    n_chk++; if (bus.left_out !== 32'd0) $display("FAIL rst_left got %h want 0", bus.left_out); else n_pass++;
    n_chk++; if (bus.write_audio_out !== 1'b0) $display("FAIL rst_write got %b want 0", bus.write_audio_out); else n_pass++;
    n_chk++; if (bus.playing !== 1'b0) $display("FAIL rst_playing got %b want 0", bus.playing); else n_pass++;
    n_chk++; if (bus.clip_done !== 1'b0 || bus.active_clip !== 2'd0) $display("FAIL rst_clip got done=%b clip=%0d want 0/0", bus.clip_done, bus.active_clip); else n_pass++;
    n_chk++; if (bus.underrun_cnt !== 8'd0) $display("FAIL rst_underrun got %0d want 0", bus.underrun_cnt); else n_pass++;
    resetn = 1'b1;
    step();
  endtask

  task automatic test_priority();
    bus.play_req = 4'b1010;
    step();
    bus.play_req = 4'b0000;
    n_chk++; if (bus.playing !== 1'b0 || bus.rom_addr !== 18'd0) $display("FAIL prio_early got play=%b addr=%0d want 0/0", bus.playing, bus.rom_addr); else n_pass++;
    step();
    n_chk++; if (bus.rom_addr !== 18'd83255) $display("FAIL prio_addr got %0d want 83255", bus.rom_addr); else n_pass++;
    n_chk++; if (bus.active_clip !== 2'd3 || bus.playing !== 1'b1) $display("FAIL prio_clip got clip=%0d play=%b want 3/1", bus.active_clip, bus.playing); else n_pass++;
    n_chk++; if (dut.pending_q !== 4'b0010) $display("FAIL prio_pending got %b want 0010", dut.pending_q); else n_pass++;
    step(); step();
    n_chk++; if (bus.write_audio_out !== 1'b0) $display("FAIL prio_early_write got %b want 0", bus.write_audio_out); else n_pass++;
    step();
    n_chk++; if (bus.write_audio_out !== 1'b1) $display("FAIL prio_first_write got %b want 1", bus.write_audio_out); else n_pass++;
    n_chk++; if (bus.left_out !== {rom_word(18'd83255), 26'd0}) $display("FAIL prio_data got %h want %h", bus.left_out, {rom_word(18'd83255), 26'd0}); else n_pass++;
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    step();
  endtask

  task automatic test_win_clip();
    int wr_n = 0, last_cyc = 0, addr_bad = 0, gap_bad = 0, data_bad = 0;
    logic [17:0] exp_addr = 18'd0;
    bit got_done = 0, rereq = 0;
    bus.play_req = 4'b0001;
    step();
    bus.play_req = 4'b0000;
    for (int i = 0; i < 16396 * DIV + 40; i++) begin
      step();
      if (bus.write_audio_out) begin
        if (bus.rom_addr !== exp_addr) addr_bad++;
        if (bus.left_out !== {rom_word(exp_addr), 26'd0}) data_bad++;
        if (wr_n > 0 && cyc - last_cyc != DIV) gap_bad++;
        last_cyc = cyc;
        wr_n++;
        exp_addr++;
      end
      if (wr_n == 100 && !rereq) begin
        bus.play_req = 4'b0001;
        rereq = 1;
      end else begin
        bus.play_req = 4'b0000;
      end
      if (bus.clip_done) begin
        got_done = 1;
        break;
      end
    end
    bus.play_req = 4'b0000;
    n_chk++; if (!got_done) $display("FAIL win_done got none want clip_done within budget"); else n_pass++;
    n_chk++; if (wr_n != 16396) $display("FAIL win_writes got %0d want 16396", wr_n); else n_pass++;
    n_chk++; if (addr_bad != 0) $display("FAIL win_addr_seq got %0d bad want 0", addr_bad); else n_pass++;
    n_chk++; if (gap_bad != 0) $display("FAIL win_period got %0d bad gaps want 0", gap_bad); else n_pass++;
    n_chk++; if (data_bad != 0) $display("FAIL win_data got %0d bad words want 0", data_bad); else n_pass++;
    n_chk++; if (bus.playing !== 1'b0 || bus.rom_addr !== 18'd16395) $display("FAIL win_end got play=%b addr=%0d want 0/16395", bus.playing, bus.rom_addr); else n_pass++;
    step();
    n_chk++; if (bus.rom_addr !== 18'd0 || bus.playing !== 1'b1 || bus.clip_done !== 1'b0) $display("FAIL win_replay got addr=%0d play=%b done=%b want 0/1/0", bus.rom_addr, bus.playing, bus.clip_done); else n_pass++;
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    step();
  endtask

  task automatic test_preempt();
    bit ok = 0;
    done_seen = 0;
    bus.play_req = 4'b0010;
    step();
    bus.play_req = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.write_audio_out) begin ok = 1; break; end
    end
    n_chk++; if (!ok || bus.rom_addr !== 18'd16396) $display("FAIL moo_first got ok=%0d addr=%0d want 1/16396", ok, bus.rom_addr); else n_pass++;
    bus.play_req = 4'b0100;
    step();
    bus.play_req = 4'b0000;
    n_chk++; if (bus.rom_addr !== 18'd16397) $display("FAIL moo_advance got %0d want 16397", bus.rom_addr); else n_pass++;
    step(); step(); step();
    n_chk++; if (bus.write_audio_out !== 1'b1 || bus.rom_addr !== 18'd16397) $display("FAIL moo_second got wr=%b addr=%0d want 1/16397", bus.write_audio_out, bus.rom_addr); else n_pass++;
    step();
    n_chk++; if (bus.rom_addr !== 18'd66983 || bus.active_clip !== 2'd2) $display("FAIL preempt_jump got addr=%0d clip=%0d want 66983/2", bus.rom_addr, bus.active_clip); else n_pass++;
    n_chk++; if (done_seen != 0) $display("FAIL preempt_done got %0d want 0", done_seen); else n_pass++;
  endtask

  task automatic test_underrun();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.write_audio_out) begin ok = 1; break; end
    end
    n_chk++; if (!ok || bus.rom_addr !== 18'd66983) $display("FAIL und_setup got ok=%0d addr=%0d want 1/66983", ok, bus.rom_addr); else n_pass++;
    bus.audio_out_allowed = 1'b0;
    wr_seen = 0;
    for (int i = 0; i < 2 * DIV; i++) step();
    bus.audio_out_allowed = 1'b1;
    n_chk++; if (wr_seen != 0 || bus.rom_addr !== 18'd66984) $display("FAIL und_blocked got wr=%0d addr=%0d want 0/66984", wr_seen, bus.rom_addr); else n_pass++;
    step();
    n_chk++; if (bus.write_audio_out !== 1'b1) $display("FAIL und_release_write got %b want 1", bus.write_audio_out); else n_pass++;
    n_chk++; if (bus.underrun_cnt !== 8'd2) $display("FAIL und_count got %0d want 2", bus.underrun_cnt); else n_pass++;
    step(); step(); step();
    n_chk++; if (wr_seen != 1 || bus.rom_addr !== 18'd66984) $display("FAIL und_hold got wr=%0d addr=%0d want 1/66984", wr_seen, bus.rom_addr); else n_pass++;
    step();
    n_chk++; if (bus.rom_addr !== 18'd66985) $display("FAIL und_resume got %0d want 66985", bus.rom_addr); else n_pass++;
  endtask

  task automatic test_stop();
    step(); step();
    done_seen = 0;
    bus.stop = 1'b1;
    bus.play_req = 4'b0001;
    step();
    bus.stop = 1'b0;
    bus.play_req = 4'b0000;
    n_chk++; if (bus.playing !== 1'b0) $display("FAIL stop_idle got playing=%b want 0", bus.playing); else n_pass++;
    n_chk++; if (dut.pending_q !== 4'b0000) $display("FAIL stop_pending got %b want 0000", dut.pending_q); else n_pass++;
    wr_seen = 0;
    for (int i = 0; i < 20; i++) step();
    n_chk++; if (wr_seen != 0) $display("FAIL stop_writes got %0d want 0", wr_seen); else n_pass++;
    n_chk++; if (done_seen != 0) $display("FAIL stop_done got %0d want 0", done_seen); else n_pass++;
    n_chk++; if (bus.playing !== 1'b0) $display("FAIL stop_stays_idle got %b want 0", bus.playing); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.play_req = 4'b1000;
    step();
    bus.play_req = 4'b0000;
    for (int i = 0; i < 10; i++) step();
    #2 resetn = 1'b0;
    #1;
    n_chk++; if (bus.rom_addr !== 18'd0 || bus.left_out !== 32'd0) $display("FAIL rmid_data got addr=%0d left=%h want 0/0", bus.rom_addr, bus.left_out); else n_pass++;
    n_chk++; if (bus.playing !== 1'b0 || bus.active_clip !== 2'd0) $display("FAIL rmid_state got play=%b clip=%0d want 0/0", bus.playing, bus.active_clip); else n_pass++;
    n_chk++; if (bus.underrun_cnt !== 8'd0) $display("FAIL rmid_underrun got %0d want 0", bus.underrun_cnt); else n_pass++;
    n_chk++; if (bus.write_audio_out !== 1'b0 || bus.clip_done !== 1'b0) $display("FAIL rmid_strobes got wr=%b done=%b want 0/0", bus.write_audio_out, bus.clip_done); else n_pass++;
    step(); step();
    resetn = 1'b1;
    wr_seen = 0;
    for (int i = 0; i < 20; i++) step();
    n_chk++; if (wr_seen != 0 || bus.playing !== 1'b0) $display("FAIL rmid_quiet got wr=%0d play=%b want 0/0", wr_seen, bus.playing); else n_pass++;
  endtask

  initial begin
    bus.play_req = 4'b0000;
    bus.stop = 1'b0;
    bus.audio_out_allowed = 1'b1;
    test_reset();
    test_priority();
    test_win_clip();
    test_preempt();
    test_underrun();
    test_stop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
